// File: rtl/alu_seq_ctrl_if.sv
// alu_seq_ctrl_if: issue handshake and datapath control bundle for alu_seq_ctrl.
// master = issuing logic / datapath side, slave = the sequencer.
interface alu_seq_ctrl_if;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm8;
  logic        err;

  modport master (
    output s, load, in,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, ALUop, shift, sximm8, err
  );

  modport slave (
    input  s, load, in,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, ALUop, shift, sximm8, err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: instruction sequencer for the register-file/shifter/ALU datapath.
// Latches a 16-bit instruction in WAIT and steps a Moore FSM that drives one
// datapath strobe group per clock. Optional feature: define ALU_SEQ_TRAP_EN to
// park illegal opcodes in a TRAP state (err=1) until reset.
module alu_seq_ctrl (
  input  logic         clk,
  input  logic         reset,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_WAIT,
    ST_DECODE,
    ST_GET_A,
    ST_GET_B,
    ST_EXEC,
    ST_WR_REG,
    ST_WR_IMM
`ifdef ALU_SEQ_TRAP_EN
    , ST_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] aluop;
    logic       err;
  } ctrl_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  ctrl_t       outs_q, outs_d;

  // Instruction classes of the latched IR (used while in DECODE)
  logic [2:0] opcode;
  logic [1:0] op;
  logic       is_mov_imm, is_mov_reg, is_alu, is_mvn;

  assign opcode     = ir_q[15:13];
  assign op         = ir_q[12:11];
  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);

  // Moore output decode for a given state and instruction word
  function automatic ctrl_t moore_out(input state_t st, input logic [15:0] ir);
    ctrl_t o;
    o = '0;
    case (st)
      ST_WAIT:   o.w = 1'b1;
      ST_GET_A:  begin
        o.readnum = ir[10:8];
        o.loada   = 1'b1;
      end
      ST_GET_B:  begin
        o.readnum = ir[2:0];
        o.loadb   = 1'b1;
      end
      ST_EXEC:   begin
        o.aluop = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        o.asel  = (ir[15:13] == 3'b110);
        if ((ir[15:13] == 3'b101) && (ir[12:11] == 2'b01))
          o.loads = 1'b1;
        else
          o.loadc = 1'b1;
      end
      ST_WR_REG: begin
        o.writenum = ir[7:5];
        o.vsel     = 2'b00;
        o.write    = 1'b1;
      end
      ST_WR_IMM: begin
        o.writenum = ir[10:8];
        o.vsel     = 2'b10;
        o.write    = 1'b1;
      end
`ifdef ALU_SEQ_TRAP_EN
      ST_TRAP:   o.err = 1'b1;
`endif
      default:   ;
    endcase
    return o;
  endfunction

  // Next-state / next-IR selection; outputs decoded from the upcoming state
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      ST_WAIT: begin
        if (bus.load) ir_d = bus.in;
        if (bus.s) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_mov_imm)
          state_d = ST_WR_IMM;
        else if (is_mov_reg || is_mvn)
          state_d = ST_GET_B;
        else if (is_alu)
          state_d = ST_GET_A;
        else
`ifdef ALU_SEQ_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_WAIT;
`endif
      end
      ST_GET_A:  state_d = ST_GET_B;
      ST_GET_B:  state_d = ST_EXEC;
      ST_EXEC:   state_d = (is_alu && (op == 2'b01)) ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: state_d = ST_WAIT;
      ST_WR_IMM: state_d = ST_WAIT;
`ifdef ALU_SEQ_TRAP_EN
      ST_TRAP:   state_d = ST_TRAP;
`endif
      default:   state_d = ST_WAIT;
    endcase
    outs_d = moore_out(state_d, ir_d);
  end

  // State, IR and output registers. Outputs are registered from the next
  // state and next IR, so they always equal the Moore decode of the current
  // state/IR while being glitch-free; async reset lands them on WAIT at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
      outs_q  <= moore_out(ST_WAIT, '0);
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      outs_q  <= outs_d;
    end
  end

  assign bus.w        = outs_q.w;
  assign bus.readnum  = outs_q.readnum;
  assign bus.writenum = outs_q.writenum;
  assign bus.write    = outs_q.write;
  assign bus.vsel     = outs_q.vsel;
  assign bus.loada    = outs_q.loada;
  assign bus.loadb    = outs_q.loadb;
  assign bus.loadc    = outs_q.loadc;
  assign bus.loads    = outs_q.loads;
  assign bus.asel     = outs_q.asel;
  assign bus.bsel     = 1'b0;
  assign bus.ALUop    = outs_q.aluop;
  assign bus.err      = outs_q.err;
  assign bus.shift    = ir_q[4:3];
  assign bus.sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed self-checking bench for alu_seq_ctrl.
// A per-instruction step list (what the datapath must see each cycle) is built
// from the instruction's class and queued; a negedge process compares the DUT
// against the queue every cycle.
module tb_alu_seq_ctrl;

  logic clk = 1'b0;
  logic reset;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic [1:0]  vsel;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  aluop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic        err;
  } snap_t;

  snap_t       expq[$];
  string       tagq[$];
  snap_t       body[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_ir = '0;

  // Idle view for an instruction word: only the IR-derived fields are live
  function automatic snap_t idle(input logic [15:0] ir);
    snap_t t;
    t        = '0;
    t.w      = 1'b1;
    t.shift  = ir[4:3];
    t.sximm8 = {{8{ir[7]}}, ir[7:0]};
    return t;
  endfunction

  // What the datapath must see on each busy cycle of one instruction
  function automatic void build(input logic [15:0] ir);
    snap_t b, t;
    logic [2:0] opc;
    logic [1:0] op;
    logic two_src, cmp;
    opc = ir[15:13];
    op  = ir[12:11];
    body.delete();
    b   = idle(ir);
    b.w = 1'b0;
    body.push_back(b);
    if (opc == 3'b110 && op == 2'b10) begin
      t = b; t.writenum = ir[10:8]; t.vsel = 2'b10; t.write = 1'b1;
      body.push_back(t);
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      two_src = (opc == 3'b101) && (op != 2'b11);
      cmp     = (opc == 3'b101) && (op == 2'b01);
      if (two_src) begin
        t = b; t.readnum = ir[10:8]; t.loada = 1'b1;
        body.push_back(t);
      end
      t = b; t.readnum = ir[2:0]; t.loadb = 1'b1;
      body.push_back(t);
      t = b;
      t.aluop = (opc == 3'b101) ? op : 2'b00;
      t.asel  = (opc == 3'b110);
      if (cmp) t.loads = 1'b1; else t.loadc = 1'b1;
      body.push_back(t);
      if (!cmp) begin
        t = b; t.writenum = ir[7:5]; t.write = 1'b1;
        body.push_back(t);
      end
    end
  endfunction

  task automatic push(input snap_t s, input string nm);
    expq.push_back(s);
    tagq.push_back(nm);
  endtask

  task automatic pin(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, want);
    end
  endtask

  // Per-cycle comparison of every DUT output against the queued expectation
  always @(negedge clk) begin
    snap_t e, a;
    string nm;
    if (expq.size() > 0) begin
      e  = expq.pop_front();
      nm = tagq.pop_front();
      a  = {bus.w, bus.readnum, bus.writenum, bus.write, bus.vsel, bus.loada,
            bus.loadb, bus.loadc, bus.loads, bus.asel, bus.bsel, bus.ALUop,
            bus.shift, bus.sximm8, bus.err};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", nm, a, e);
      end
    end
  end

  task automatic idle_cycles(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      push(idle(model_ir), nm);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, input string nm);
    int n;
    push(idle(model_ir), {nm, "_wait"});
    build(ir);
    n = body.size();
    foreach (body[i]) push(body[i], $sformatf("%s_c%0d", nm, i));
    model_ir = ir;
    bus.in = ir; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.s = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input string nm);
    reset    = 1'b1;
    model_ir = '0;
    idle_cycles(2, nm);
    reset    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.s = 1'b0; bus.load = 1'b0; bus.in = '0;

    // Model pins against hand-computed values
    build(16'hD205);
    pin("m_movimm_len", body.size(), 2);
    pin("m_movimm_wn", int'(body[1].writenum), 2);
    pin("m_movimm_vsel", int'(body[1].vsel), 2);
    pin("m_movimm_imm", int'(body[1].sximm8), 16'h0005);
    build(16'hD2FF);
    pin("m_movimm_neg", int'(body[1].sximm8), 16'hFFFF);
    build(16'hA0E1);
    pin("m_add_len", body.size(), 5);
    pin("m_add_rna", int'(body[1].readnum), 0);
    pin("m_add_rnb", int'(body[2].readnum), 1);
    pin("m_add_wn", int'(body[4].writenum), 7);
    build(16'hA901);
    pin("m_cmp_len", body.size(), 4);
    pin("m_cmp_aluop", int'(body[3].aluop), 1);
    pin("m_cmp_loads", int'(body[3].loads), 1);
    build(16'hC0B9);
    pin("m_movreg_len", body.size(), 4);
    pin("m_movreg_asel", int'(body[2].asel), 1);
    pin("m_movreg_wn", int'(body[3].writenum), 5);
    build(16'hB8A3);
    pin("m_mvn_aluop", int'(body[2].aluop), 3);
    build(16'hE000);
    pin("m_ill_len", body.size(), 1);

    // Reset state
    @(posedge clk); #1;
    reset_pulse("reset");

    run_instr(16'hD205, "mov_imm5");
    run_instr(16'hD2FF, "mov_immff");
    run_instr(16'hA0E1, "add");
    run_instr(16'hA901, "cmp");
    run_instr(16'hC0B9, "mov_reg");
    run_instr(16'hB8A3, "mvn");
    run_instr(16'hB443, "and");

    // Illegal opcode
`ifdef ALU_SEQ_TRAP_EN
    begin
      snap_t tr;
      push(idle(model_ir), "ill_wait");
      build(16'hE000);
      push(body[0], "ill_dec");
      tr = body[0]; tr.err = 1'b1;
      for (int i = 0; i < 3; i++) push(tr, "ill_trap");
      model_ir = 16'hE000;
      bus.in = 16'hE000; bus.load = 1'b1; bus.s = 1'b1;
      @(posedge clk); #1;
      bus.load = 1'b0; bus.s = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset_pulse("trap_reset");
    end
`else
    run_instr(16'hE000, "illegal");
`endif
    idle_cycles(1, "post_ill");

    // Reset during GET_B of an ADD: no write afterwards, IR cleared
    push(idle(model_ir), "rst_add_wait");
    build(16'hA0E1);
    push(body[0], "rst_add_c0");
    push(body[1], "rst_add_c1");
    model_ir = 16'hA0E1;
    bus.in = 16'hA0E1; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.load = 1'b0; bus.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_pulse("rst_add_hold");
    idle_cycles(6, "rst_add_after");

    // Back-to-back with s held; load outside WAIT must be ignored
    push(idle(model_ir), "b2b_wait0");
    build(16'hD205);
    foreach (body[i]) push(body[i], $sformatf("b2b_a%0d", i));
    model_ir = 16'hD205;
    bus.in = 16'hD205; bus.load = 1'b1; bus.s = 1'b1;
    @(posedge clk); #1;
    bus.in = 16'hE000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.load = 1'b0;
    push(idle(model_ir), "b2b_wait1");
    foreach (body[i]) push(body[i], $sformatf("b2b_b%0d", i));
    @(posedge clk); #1;
    bus.s = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_cycles(2, "end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Instruction-level sequencer for the register-file/shifter/ALU datapath. It latches a 16-bit instruction, decodes it, and walks a Moore FSM that drives the datapath's register-read, operand-load, ALU-op, status-load and write-back strobes one step per clock. A `w` (idle) flag gives the issuing logic a start/done handshake. It sits between instruction fetch and the datapath, replacing hand-driven control from testbench or switch inputs.

## Interface
- No parameters; all widths fixed (16-bit instruction, 3-bit register numbers).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; forces WAIT, clears IR.
- `s` in 1: start; sampled only in WAIT.
- `load` in 1: IR load enable; honoured only in WAIT.
- `in` in 16: instruction word.
- `w` out 1: 1 only in WAIT (ready for next instruction).
- `readnum` out 3: register-file read address.
- `writenum` out 3: register-file write address.
- `write` out 1: register-file write strobe.
- `vsel` out 2: write-back source: 00=C, 01=reserved (PC), 10=sximm8, 11=mdata.
- `loada`, `loadb`, `loadc`, `loads` out 1 each: A, B, C, status register load strobes.
- `asel` out 1: 1 forces ALU A input to 0.
- `bsel` out 1: 1 selects sximm5 for B (always 0 in this block).
- `ALUop` out 2: 00 add, 01 sub, 10 and, 11 not-B.
- `shift` out 2: shifter control = IR[4:3] at all times.
- `sximm8` out 16: IR[7:0] sign-extended.
- `err` out 1: illegal-opcode flag (see Configuration).

## Operation
- IR fields: opcode IR[15:13], op IR[12:11], Rn IR[10:8], Rd IR[7:5], sh IR[4:3], Rm IR[2:0].
- Legal: 110/10 MOV Rn,#imm8; 110/00 MOV Rd,Rm{,sh}; 101/00 ADD; 101/01 CMP; 101/10 AND; 101/11 MVN. All other opcode/op combinations are illegal.
- States: WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM (+TRAP if enabled).
- WAIT: `w`=1; `s`=1 -> DECODE.
- DECODE: MOV imm -> WR_IMM; MOV reg, MVN -> GET_B; ADD/CMP/AND -> GET_A; illegal -> WAIT (or TRAP).
- GET_A: `readnum`=Rn, `loada`=1 -> GET_B.
- GET_B: `readnum`=Rm, `loadb`=1 -> EXEC.
- EXEC: `ALUop`=op for opcode 101, 00 for MOV reg; `asel`=1 only for MOV reg; CMP: `loads`=1, `loadc`=0 -> WAIT; others: `loadc`=1 -> WR_REG.
- WR_REG: `writenum`=Rd, `vsel`=00, `write`=1 -> WAIT.
- WR_IMM: `writenum`=Rn, `vsel`=10, `write`=1 -> WAIT.
- Strobes not listed for a state are 0; `readnum`/`writenum` default 000; `vsel` defaults 00.
- Outputs are combinational from state and IR only (Moore); no glitch-sensitive path from `s`/`in`.

## Timing
- Reset (async): state=WAIT, IR=0, `w`=1, all strobes 0, `err`=0, `ALUop`=00, `shift`=00, `sximm8`=0; holds while asserted.
- Reset mid-instruction: in-flight instruction abandoned; no partial write after reset asserts.
- `load` and `s` both high in WAIT at edge N: IR takes `in`; DECODE at N+1 uses the new IR.
- `load` outside WAIT ignored; `s` outside WAIT ignored (no queueing).
- Cycles with `w`=0 after the start edge: MOV imm 2; MOV reg 4; MVN 4; CMP 4; ADD/AND 5; illegal 1.
- Exactly one `write` pulse per writing instruction; CMP never pulses `write` or `loadc`.
- Back-to-back: `s` held high re-starts immediately on return to WAIT (one WAIT cycle with `w`=1 between instructions).

## Configuration
- `ALU_SEQ_TRAP_EN` defined: illegal opcode goes DECODE -> TRAP; TRAP holds `w`=0, `err`=1, all strobes 0, until `reset`.
- Undefined: illegal opcode goes DECODE -> WAIT; TRAP state absent; `err` tied 0.

## Test plan
- Reset mid-ADD (during GET_B) -> `w`=1 and all strobes 0 within the same cycle, IR=0, no `write` pulse afterwards.
- Load 0xD205 (MOV R2,#5), pulse `s` -> WR_IMM cycle shows `writenum`=2, `vsel`=10, `sximm8`=0x0005, `write`=1; `w` low exactly 2 cycles. Repeat with imm8=0xFF -> `sximm8`=0xFFFF.
- Load 0xA0E1 (ADD R7,R0,R1) -> `readnum` 0 with `loada`, then 1 with `loadb`; EXEC `ALUop`=00, `loadc`=1; WR_REG `writenum`=7; `w` low 5 cycles.
- Load 0xA901 (CMP R1,R1) -> EXEC `ALUop`=01, `loads`=1, `loadc`=0; no `write`; `w` low 4 cycles.
- Load 0xC0B9 (MOV R5,R1,sh=11) -> EXEC `asel`=1, `ALUop`=00, `shift`=11; WR_REG `writenum`=5. Load 0xB8A3 (MVN R5,R3) -> EXEC `ALUop`=11.
- Load 0xE000 (illegal), pulse `s`: with `ALU_SEQ_TRAP_EN` -> `err`=1, `w`=0 until reset; without -> back to WAIT after 1 cycle, `err`=0, no strobes.
